commit_trace_buffer: RTL and testbench

Observation stage downstream of the processor top level. Captures architectural commit events (regfile writes and dmem stores) once per processor-clock rising edge, then queues them as 48-bit records in a FIFO. Drains them over a valid/ready stream to the grading/debug harness. Runs on the undivided base clock and treats the divided processor clock as a sampled level input.

---
 rtl/trace_pkg.sv | 30 +++
 rtl/trace_fifo.sv | 50 +++++
 rtl/commit_trace_buffer.sv | 137 +++++++++++++
 tb/tb_commit_trace_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared record definitions for the commit trace path: record types, width,
// field offsets and a record builder.
package trace_pkg;

    localparam int unsigned REC_W    = 48;
    localparam int unsigned TYPE_LSB = 46;
    localparam int unsigned IDX_LSB  = 32;
    localparam int unsigned VAL_LSB  = 0;

    typedef enum logic [1:0] {
        REC_NONE  = 2'b00,
        REC_REG   = 2'b01,
        REC_STORE = 2'b10
    } rec_type_e;

    // Bits 45:44 stay zero.
    function automatic logic [REC_W-1:0] make_record(
        input rec_type_e   rtype,
        input logic [11:0] index,
        input logic [31:0] value
    );
        logic [REC_W-1:0] rec;
        rec                  = '0;
        rec[TYPE_LSB +: 2]   = rtype;
        rec[IDX_LSB  +: 12]  = index;
        rec[VAL_LSB  +: 32]  = value;
        return rec;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Register-array FIFO for trace records; head entry is presented combinationally.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [REC_W-1:0]         push_data,
    input  logic                     pop,
    output logic [REC_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (level == FULL_LVL);

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures regfile writes and dmem stores on each processor-clock rise and
// queues them as 48-bit records for a valid/ready consumer.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   processor_clock,
    input  logic                   trace_en,
    input  logic                   ctrl_writeEnable,
    input  logic [4:0]             ctrl_writeReg,
    input  logic [31:0]            data_writeReg,
    input  logic                   wren,
    input  logic [11:0]            address_dmem,
    input  logic [31:0]            data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REC_W-1:0]       out_record,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count,
    output logic [$clog2(DEPTH):0] level
);

    logic              pclk_q;
    logic              sh_write_en;
    logic [4:0]        sh_write_reg;
    logic [31:0]       sh_write_data;
    logic              sh_wren;
    logic [11:0]       sh_address;
    logic [31:0]       sh_data;

    logic              pend_valid;
    logic [REC_W-1:0]  pend_rec;
    logic [REC_W-1:0]  last_rec;

    logic              commit_event;
    logic              reg_cand;
    logic              store_cand;
    logic [REC_W-1:0]  reg_rec;
    logic [REC_W-1:0]  store_rec;

    logic              push;
    logic [REC_W-1:0]  push_data;
    logic              push_ok;
    logic              drop;
    logic              pop;
    logic              full;
    logic [REC_W-1:0]  head_data;

    assign commit_event = processor_clock & ~pclk_q & trace_en;
    assign reg_cand     = commit_event & sh_write_en & (sh_write_reg != '0);
    assign store_cand   = commit_event & sh_wren;
    assign reg_rec      = make_record(REC_REG, {7'b0, sh_write_reg}, sh_write_data);
    assign store_rec    = make_record(REC_STORE, sh_address, sh_data);

    // STORE wins the event cycle; a paired REG goes out from pending next cycle.
    always_comb begin
        push      = 1'b0;
        push_data = pend_rec;
        if (store_cand) begin
            push      = 1'b1;
            push_data = store_rec;
        end else if (reg_cand) begin
            push      = 1'b1;
            push_data = reg_rec;
        end else if (pend_valid) begin
            push      = 1'b1;
            push_data = pend_rec;
        end
    end

    assign out_valid  = (level != '0);
    assign pop        = out_valid & out_ready;
    assign push_ok    = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign out_record = out_valid ? head_data : last_rec;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pclk_q        <= 1'b0;
            sh_write_en   <= 1'b0;
            sh_write_reg  <= '0;
            sh_write_data <= '0;
            sh_wren       <= 1'b0;
            sh_address    <= '0;
            sh_data       <= '0;
            pend_valid    <= 1'b0;
            pend_rec      <= '0;
            last_rec      <= '0;
            overflow      <= 1'b0;
            drop_count    <= '0;
        end else begin
            pclk_q        <= processor_clock;
            sh_write_en   <= ctrl_writeEnable;
            sh_write_reg  <= ctrl_writeReg;
            sh_write_data <= data_writeReg;
            sh_wren       <= wren;
            sh_address    <= address_dmem;
            sh_data       <= data;

            if (store_cand && reg_cand) begin
                pend_valid <= 1'b1;
                pend_rec   <= reg_rec;
            end else if (!store_cand && !reg_cand) begin
                pend_valid <= 1'b0;
            end

            if (pop) begin
                last_rec <= head_data;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

    trace_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .level     (level),
        .full      (full)
    );

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomised self-checking bench for commit_trace_buffer against a queue-based
// transaction model.
module tb_commit_trace_buffer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              processor_clock;
    logic              trace_en;
    logic              ctrl_writeEnable;
    logic [4:0]        ctrl_writeReg;
    logic [31:0]       data_writeReg;
    logic              wren;
    logic [11:0]       address_dmem;
    logic [31:0]       data;
    logic              out_valid;
    logic              out_ready;
    logic [47:0]       out_record;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic [LW-1:0]     level;

    always #5 clock = ~clock;

    commit_trace_buffer #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .processor_clock  (processor_clock),
        .trace_en         (trace_en),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .wren             (wren),
        .address_dmem     (address_dmem),
        .data             (data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_record       (out_record),
        .overflow         (overflow),
        .drop_count       (drop_count),
        .level            (level)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction model: records scheduled per clock edge, queue of accepted records.
    logic [47:0] sched [int];
    logic [47:0] mq [$];
    logic [47:0] m_last;
    bit          m_ovf;
    int unsigned m_drop;
    int          cyc = 0;

    always @(posedge clock) begin
        bit popped;
        cyc++;
        if (!reset) begin
            mq.delete();
            m_last = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            popped = out_ready && (mq.size() != 0);
            if (popped) m_last = mq.pop_front();
            if (sched.exists(cyc)) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(sched[cyc]);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < (2 ** DROP_W) - 1) m_drop++;
                end
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clock) begin
        if (chk_en && reset) begin
            check_eq("out_valid",  64'(out_valid),  64'(mq.size() != 0));
            check_eq("level",      64'(level),      64'(mq.size()));
            check_eq("out_record", 64'(out_record), 64'((mq.size() != 0) ? mq[0] : m_last));
            check_eq("overflow",   64'(overflow),   64'(m_ovf));
            check_eq("drop_count", 64'(drop_count), 64'(m_drop));
        end
    end

    int rdy_mode = 0;

    task automatic tick();
        @(negedge clock);
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One processor cycle: two base clocks low, then two high.
    task automatic proc_cycle(input bit ten, input bit we, input logic [4:0] wr,
                              input logic [31:0] wd, input bit st,
                              input logic [11:0] ad, input logic [31:0] dd);
        logic [47:0] st_rec;
        logic [47:0] rg_rec;
        bit          rg;
        tick();
        trace_en         = ten;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        wren             = st;
        address_dmem     = ad;
        data             = dd;
        processor_clock  = 1'b0;
        tick();
        tick();
        processor_clock = 1'b1;
        st_rec = {2'b10, 2'b00, ad, dd};
        rg_rec = {2'b01, 2'b00, 7'b0, wr, wd};
        rg     = we && (wr != 5'd0);
        if (ten) begin
            if (st) begin
                sched[cyc + 1] = st_rec;
                if (rg) sched[cyc + 2] = rg_rec;
            end else if (rg) begin
                sched[cyc + 1] = rg_rec;
            end
        end
        tick();
    endtask

    task automatic drain();
        rdy_mode = 1;
        repeat (DEPTH + 4) tick();
    endtask

    initial begin
        reset            = 1'b0;
        processor_clock  = 1'b0;
        trace_en         = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        wren             = 1'b0;
        address_dmem     = '0;
        data             = '0;
        out_ready        = 1'b0;

        repeat (3) @(negedge clock);
        check_eq("rst_out_valid",  64'(out_valid),  64'(0));
        check_eq("rst_out_record", 64'(out_record), 64'(0));
        check_eq("rst_overflow",   64'(overflow),   64'(0));
        check_eq("rst_drop_count", 64'(drop_count), 64'(0));
        check_eq("rst_level",      64'(level),      64'(0));
        reset  = 1'b1;
        chk_en = 1'b1;

        // Single reg write r5
        rdy_mode = 0;
        proc_cycle(1, 1, 5'd5, 32'hDEADBEEF, 0, 12'h0, 32'h0);
        check_eq("t1_level", 64'(level), 64'(1));
        check_eq("t1_rec",   64'(out_record), 64'h4005_DEADBEEF);
        rdy_mode = 1;
        tick();
        tick();
        check_eq("t1_level_after", 64'(level), 64'(0));
        check_eq("t1_hold_rec",    64'(out_record), 64'h4005_DEADBEEF);

        // Store and reg write on the same event
        rdy_mode = 0;
        proc_cycle(1, 1, 5'd2, 32'h22, 1, 12'h123, 32'h11);
        tick();
        check_eq("t2_level", 64'(level), 64'(2));
        check_eq("t2_store", 64'(out_record), 64'h8123_00000011);
        rdy_mode = 1;
        tick();
        tick();
        check_eq("t2_reg", 64'(out_record), 64'h4002_00000022);
        tick();
        check_eq("t2_level_after", 64'(level), 64'(0));

        // r0 write is never recorded
        proc_cycle(1, 1, 5'd0, 32'h55, 0, 12'h0, 32'h0);
        tick();
        check_eq("t3_level", 64'(level), 64'(0));
        check_eq("t3_hold",  64'(out_record), 64'h4002_00000022);

        // Overflow: 20 events into a 16-deep FIFO
        rdy_mode = 0;
        for (int i = 0; i < 20; i++) begin
            proc_cycle(1, 1, 5'($urandom_range(1, 31)), $urandom, 0, 12'h0, 32'h0);
        end
        tick();
        check_eq("t4_level",      64'(level),      64'(16));
        check_eq("t4_overflow",   64'(overflow),   64'(1));
        check_eq("t4_drop_count", 64'(drop_count), 64'(4));
        drain();
        check_eq("t4_level_after", 64'(level), 64'(0));

        // trace_en gating
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            proc_cycle(0, 1, 5'd7, $urandom, 1, 12'($urandom), $urandom);
        end
        proc_cycle(1, 1, 5'd9, 32'h0000_0999, 0, 12'h0, 32'h0);
        tick();
        check_eq("t5_level", 64'(level), 64'(1));
        check_eq("t5_rec",   64'(out_record), 64'h4009_00000999);
        drain();

        // Asynchronous reset while records are queued
        rdy_mode = 0;
        for (int i = 0; i < 7; i++) begin
            proc_cycle(1, 1, 5'($urandom_range(1, 31)), $urandom, 0, 12'h0, 32'h0);
        end
        tick();
        check_eq("t6_level_pre", 64'(level), 64'(7));
        chk_en = 1'b0;
        processor_clock = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_eq("t6_level",      64'(level),      64'(0));
        check_eq("t6_out_valid",  64'(out_valid),  64'(0));
        check_eq("t6_overflow",   64'(overflow),   64'(0));
        check_eq("t6_drop_count", 64'(drop_count), 64'(0));
        check_eq("t6_out_record", 64'(out_record), 64'(0));
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Random traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            proc_cycle(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                       12'($urandom), $urandom);
        end
        drain();
        check_eq("final_level", 64'(level), 64'(0));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
